prefetch_issue_queue: RTL and testbench

Consumer side of the degree-3 stride prefetcher's candidate interface. Accepts up to three prefetch candidate addresses per cycle (fire-and-forget pulses, no backpressure) and buffers them in a circular FIFO. Drops duplicates and overflow. Issues one block-aligned prefetch request per cycle to the L2/memory request port over a valid/ready handshake.

---
 rtl/pref_pkg.sv | 17 +
 rtl/pref_cam_match.sv | 20 ++
 rtl/prefetch_issue_queue.sv | 157 +++++++++++++++
 tb/tb_prefetch_issue_queue.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pref_pkg.sv
// Shared definitions for the stride prefetcher and its issue queue.
package pref_pkg;

  localparam int unsigned ADDR_SIZE       = 64;
  localparam int unsigned LOG2_BLOCK_SIZE = 6;
  localparam int unsigned LOG2_PAGE_SIZE  = 12;

  // Candidates offered per cycle by the degree-3 prefetcher.
  localparam int unsigned NUM_CAND        = 3;

  // Full byte address.
  typedef logic [ADDR_SIZE-1:0] addr_t;

  // Cache-line (block) address: byte address with the block offset removed.
  typedef logic [ADDR_SIZE-LOG2_BLOCK_SIZE-1:0] cla_t;

endpackage

// File: rtl/pref_cam_match.sv
// Single-key lookup against every queue entry; only valid entries can hit.
module pref_cam_match #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 58
)(
  input  logic [WIDTH-1:0]            key,
  input  logic [DEPTH-1:0][WIDTH-1:0] entries,
  input  logic [DEPTH-1:0]            valid,
  output logic                        hit
);

  // OR-reduce the per-entry equality, masked by the entry valid bit.
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i] == key)) hit = 1'b1;
    end
  end

endmodule

// File: rtl/prefetch_issue_queue.sv
// Buffers up to three prefetch candidates per cycle in a circular FIFO,
// filters duplicate blocks, counts overflow drops and issues one
// block-aligned request per cycle over valid/ready.
module prefetch_issue_queue
  import pref_pkg::NUM_CAND;
#(
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned ADDR_SIZE       = pref_pkg::ADDR_SIZE,
  parameter int unsigned LOG2_BLOCK_SIZE = pref_pkg::LOG2_BLOCK_SIZE
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_SIZE-1:0]       pref_addr1_i,
  input  logic                       pref_valid1_i,
  input  logic [ADDR_SIZE-1:0]       pref_addr2_i,
  input  logic                       pref_valid2_i,
  input  logic [ADDR_SIZE-1:0]       pref_addr3_i,
  input  logic                       pref_valid3_i,
  input  logic                       flush_i,
  output logic                       req_valid_o,
  output logic [ADDR_SIZE-1:0]       req_addr_o,
  input  logic                       req_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
  output logic [15:0]                drop_count_o
);

  localparam int unsigned BW = ADDR_SIZE - LOG2_BLOCK_SIZE;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  // Queue state
  logic [PW-1:0]             head_q;
  logic [PW-1:0]             tail_q;
  logic [CW-1:0]             count_q;
  logic [DEPTH-1:0]          valid_q;
  logic [DEPTH-1:0][BW-1:0]  mem_q;
  logic [15:0]               drop_q;

  // Per-candidate decode, index 0 is candidate 1
  logic [NUM_CAND-1:0]          cand_valid;
  logic [NUM_CAND-1:0][BW-1:0]  cand_blk;
  logic [NUM_CAND-1:0]          cam_hit;
  logic [NUM_CAND-1:0]          cand_acc;
  logic [NUM_CAND-1:0][PW-1:0]  cand_slot;

  logic                         pop;
  logic                         dup;
  int unsigned                  free_slots;
  int unsigned                  acc_n;
  int unsigned                  ovf_n;
  logic [CW-1:0]                count_d;
  logic [16:0]                  drop_sum;
  logic [15:0]                  drop_d;

  // Block offsets never reach the queue.
  logic unused_offset;
  assign unused_offset = ^{pref_addr1_i[LOG2_BLOCK_SIZE-1:0],
                           pref_addr2_i[LOG2_BLOCK_SIZE-1:0],
                           pref_addr3_i[LOG2_BLOCK_SIZE-1:0]};

  assign cand_valid  = {pref_valid3_i, pref_valid2_i, pref_valid1_i};
  assign cand_blk[0] = pref_addr1_i[ADDR_SIZE-1:LOG2_BLOCK_SIZE];
  assign cand_blk[1] = pref_addr2_i[ADDR_SIZE-1:LOG2_BLOCK_SIZE];
  assign cand_blk[2] = pref_addr3_i[ADDR_SIZE-1:LOG2_BLOCK_SIZE];

  // Outputs come straight from registered state.
  assign req_valid_o  = (count_q != '0);
  assign req_addr_o   = {mem_q[head_q], {LOG2_BLOCK_SIZE{1'b0}}};
  assign occupancy_o  = count_q;
  assign drop_count_o = drop_q;
  assign pop          = req_valid_o && req_ready_i;

  // Queue-content duplicate lookup, one CAM port per candidate.
  for (genvar g = 0; g < NUM_CAND; g++) begin : g_cam
    pref_cam_match #(
      .DEPTH (DEPTH),
      .WIDTH (BW)
    ) u_cam (
      .key     (cand_blk[g]),
      .entries (mem_q),
      .valid   (valid_q),
      .hit     (cam_hit[g])
    );
  end

  // Sequential acceptance in candidate order: dedup, then claim a free slot.
  // The slot popped this cycle is already counted as free, so a full queue
  // with a pop can still take one candidate into the head slot.
  always_comb begin
    free_slots = DEPTH - 32'(count_q) + 32'(pop);
    acc_n      = 0;
    ovf_n      = 0;
    dup        = 1'b0;
    cand_acc   = '0;
    cand_slot  = '0;
    for (int unsigned k = 0; k < NUM_CAND; k++) begin
      dup = cam_hit[k];
      for (int unsigned j = 0; j < k; j++) begin
        if (cand_acc[j] && (cand_blk[j] == cand_blk[k])) dup = 1'b1;
      end
      if (cand_valid[k] && !dup) begin
        if (acc_n < free_slots) begin
          cand_acc[k]  = 1'b1;
          cand_slot[k] = tail_q + PW'(acc_n);
          acc_n        = acc_n + 1;
        end else begin
          ovf_n = ovf_n + 1;
        end
      end
    end
  end

  // Next occupancy and saturating overflow-drop count.
  always_comb begin
    count_d  = count_q + CW'(acc_n) - CW'(pop);
    drop_sum = {1'b0, drop_q} + 17'(ovf_n);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Pointers, count, valid bits and drop counter; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      drop_q  <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      // Clear the popped entry first so a push into the same slot wins.
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      for (int unsigned k = 0; k < NUM_CAND; k++) begin
        if (cand_acc[k]) valid_q[cand_slot[k]] <= 1'b1;
      end
      tail_q  <= tail_q + PW'(acc_n);
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  // Entry payload storage; contents are qualified by valid_q.
  always_ff @(posedge clk) begin
    if (!flush_i) begin
      for (int unsigned k = 0; k < NUM_CAND; k++) begin
        if (cand_acc[k]) mem_q[cand_slot[k]] <= cand_blk[k];
      end
    end
  end

endmodule

// File: tb/tb_prefetch_issue_queue.sv
// Scoreboard bench for prefetch_issue_queue: a queue model predicts every
// issued address, occupancy and drop count.
module tb_prefetch_issue_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 64;
  localparam int unsigned LB    = 6;
  localparam int unsigned BW    = AW - LB;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pref_addr1_i, pref_addr2_i, pref_addr3_i;
  logic          pref_valid1_i, pref_valid2_i, pref_valid3_i;
  logic          flush_i;
  logic          req_valid_o;
  logic [AW-1:0] req_addr_o;
  logic          req_ready_i;
  logic [3:0]    occupancy_o;
  logic [15:0]   drop_count_o;

  int n_vec = 0;
  int n_err = 0;

  logic [BW-1:0] exp_q[$];
  int            exp_drops = 0;

  always #5 clk = ~clk;

  prefetch_issue_queue #(
    .DEPTH           (DEPTH),
    .ADDR_SIZE       (AW),
    .LOG2_BLOCK_SIZE (LB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pref_addr1_i  (pref_addr1_i),
    .pref_valid1_i (pref_valid1_i),
    .pref_addr2_i  (pref_addr2_i),
    .pref_valid2_i (pref_valid2_i),
    .pref_addr3_i  (pref_addr3_i),
    .pref_valid3_i (pref_valid3_i),
    .flush_i       (flush_i),
    .req_valid_o   (req_valid_o),
    .req_addr_o    (req_addr_o),
    .req_ready_i   (req_ready_i),
    .occupancy_o   (occupancy_o),
    .drop_count_o  (drop_count_o)
  );

  // One clock: drive at negedge, score any handshake, update the model,
  // return 1ns after the rising edge.
  task automatic cycle(input bit v1, input logic [AW-1:0] a1,
                       input bit v2, input logic [AW-1:0] a2,
                       input bit v3, input logic [AW-1:0] a3,
                       input bit fl, input bit rdy);
    bit            vv[3];
    logic [BW-1:0] bb[3];
    logic [BW-1:0] acc[$];
    bit            dup;
    bit            pop;
    int            free;
    int            ovf;
    @(negedge clk);
    pref_valid1_i = v1; pref_addr1_i = a1;
    pref_valid2_i = v2; pref_addr2_i = a2;
    pref_valid3_i = v3; pref_addr3_i = a3;
    flush_i = fl; req_ready_i = rdy;
    vv[0] = v1; vv[1] = v2; vv[2] = v3;
    bb[0] = a1[AW-1:LB]; bb[1] = a2[AW-1:LB]; bb[2] = a3[AW-1:LB];
    n_vec++;
    if (req_valid_o !== (exp_q.size() != 0)) begin
      n_err++;
      $display("FAIL sb_req_valid: got %b expected %b", req_valid_o, exp_q.size() != 0);
    end
    pop = rdy && (exp_q.size() != 0);
    if (pop) begin
      n_vec++;
      if (req_addr_o !== {exp_q[0], 6'b0}) begin
        n_err++;
        $display("FAIL sb_req_addr: got %h expected %h", req_addr_o, {exp_q[0], 6'b0});
      end
    end
    free = DEPTH - exp_q.size() + (pop ? 1 : 0);
    ovf  = 0;
    for (int k = 0; k < 3; k++) begin
      if (vv[k]) begin
        dup = 1'b0;
        foreach (exp_q[i]) if (exp_q[i] == bb[k]) dup = 1'b1;
        foreach (acc[i])   if (acc[i] == bb[k])   dup = 1'b1;
        if (!dup) begin
          if (acc.size() < free) acc.push_back(bb[k]);
          else ovf++;
        end
      end
    end
    if (fl) begin
      exp_q.delete();
    end else begin
      if (pop) void'(exp_q.pop_front());
      foreach (acc[i]) exp_q.push_back(acc[i]);
      exp_drops = (exp_drops + ovf > 65535) ? 65535 : exp_drops + ovf;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy);
    cycle(0, 64'hDEAD_BEEF_0000_0000, 0, 64'hFFFF_FFFF_FFFF_FFC0, 0, 64'h40, 0, rdy);
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) idle(1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    pref_valid1_i = 0; pref_valid2_i = 0; pref_valid3_i = 0;
    pref_addr1_i = '0; pref_addr2_i = '0; pref_addr3_i = '0;
    flush_i = 0; req_ready_i = 0;
    #22;
    n_vec++; if (req_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", req_valid_o); end
    n_vec++; if (occupancy_o !== 4'd0) begin n_err++; $display("FAIL reset_occ: got %0d expected 0", occupancy_o); end
    n_vec++; if (drop_count_o !== 16'd0) begin n_err++; $display("FAIL reset_drops: got %0d expected 0", drop_count_o); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_basic();
    cycle(1, 64'h1040, 1, 64'h1080, 1, 64'h10C0, 0, 1);
    n_vec++; if (req_valid_o !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b expected 1", req_valid_o); end
    n_vec++; if (req_addr_o !== 64'h1040) begin n_err++; $display("FAIL basic_addr: got %h expected 1040", req_addr_o); end
    n_vec++; if (occupancy_o !== 4'd3) begin n_err++; $display("FAIL basic_occ: got %0d expected 3", occupancy_o); end
    idle(1); idle(1); idle(1);
    n_vec++; if (occupancy_o !== 4'd0) begin n_err++; $display("FAIL basic_drained: got %0d expected 0", occupancy_o); end
    n_vec++; if (req_valid_o !== 1'b0) begin n_err++; $display("FAIL basic_empty_valid: got %b expected 0", req_valid_o); end
    idle(1);
    n_vec++; if (occupancy_o !== 4'd0) begin n_err++; $display("FAIL basic_invalid_ignored: got %0d expected 0", occupancy_o); end
  endtask

  task automatic test_dup();
    cycle(1, 64'h2000, 0, 64'h0, 0, 64'h0, 0, 0);
    cycle(1, 64'h2010, 1, 64'h2040, 0, 64'h0, 0, 0);
    n_vec++; if (occupancy_o !== 4'd2) begin n_err++; $display("FAIL dup_occ: got %0d expected 2", occupancy_o); end
    n_vec++; if (drop_count_o !== 16'd0) begin n_err++; $display("FAIL dup_drops: got %0d expected 0", drop_count_o); end
    cycle(1, 64'h3000, 1, 64'h3008, 1, 64'h3000, 0, 0);
    n_vec++; if (occupancy_o !== 4'd3) begin n_err++; $display("FAIL dup_same_cycle: got %0d expected 3", occupancy_o); end
    // head (0x2000) is being popped this cycle but still blocks a duplicate
    cycle(1, 64'h2020, 0, 64'h0, 0, 64'h0, 0, 1);
    n_vec++; if (occupancy_o !== 4'd2) begin n_err++; $display("FAIL dup_popping_head: got %0d expected 2", occupancy_o); end
    drain();
    n_vec++; if (occupancy_o !== 4'd0) begin n_err++; $display("FAIL dup_drained: got %0d expected 0", occupancy_o); end
  endtask

  task automatic test_overflow();
    int d0;
    d0 = exp_drops;
    cycle(1, 64'h7000, 1, 64'h7040, 1, 64'h7080, 0, 0);
    cycle(1, 64'h70C0, 1, 64'h7100, 1, 64'h7140, 0, 0);
    cycle(1, 64'h7180, 0, 64'h0, 0, 64'h0, 0, 0);
    n_vec++; if (occupancy_o !== 4'd7) begin n_err++; $display("FAIL ovf_fill: got %0d expected 7", occupancy_o); end
    cycle(1, 64'h71C0, 1, 64'h7200, 1, 64'h7240, 0, 0);
    n_vec++; if (occupancy_o !== 4'd8) begin n_err++; $display("FAIL ovf_occ: got %0d expected 8", occupancy_o); end
    n_vec++; if (drop_count_o !== 16'(d0 + 2)) begin n_err++; $display("FAIL ovf_drops: got %0d expected %0d", drop_count_o, d0 + 2); end
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 8; i++) begin
      cycle(1, 64'h9000 + 64'(i) * 64'h40, 0, 64'h0, 0, 64'h0, 0, 1);
      n_vec++; if (occupancy_o !== 4'd8) begin n_err++; $display("FAIL wrap_full_occ: got %0d expected 8", occupancy_o); end
    end
    drain();
    n_vec++; if (occupancy_o !== 4'd0) begin n_err++; $display("FAIL wrap_drained: got %0d expected 0", occupancy_o); end
  endtask

  task automatic test_flush();
    int d0;
    cycle(1, 64'hA000, 1, 64'hA040, 1, 64'hA080, 0, 0);
    cycle(1, 64'hA0C0, 1, 64'hA100, 0, 64'h0, 0, 0);
    n_vec++; if (occupancy_o !== 4'd5) begin n_err++; $display("FAIL flush_pre_occ: got %0d expected 5", occupancy_o); end
    d0 = exp_drops;
    cycle(1, 64'hB000, 1, 64'hB040, 1, 64'hB080, 1, 0);
    n_vec++; if (occupancy_o !== 4'd0) begin n_err++; $display("FAIL flush_occ: got %0d expected 0", occupancy_o); end
    n_vec++; if (req_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b expected 0", req_valid_o); end
    n_vec++; if (drop_count_o !== 16'(d0)) begin n_err++; $display("FAIL flush_drops: got %0d expected %0d", drop_count_o, d0); end
  endtask

  task automatic test_random();
    logic [AW-1:0] a[3];
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 3; k++)
        a[k] = 64'h8000 + 64'($urandom_range(0, 15)) * 64'h40 + 64'($urandom_range(0, 63));
      cycle($urandom_range(0, 1) == 1, a[0], $urandom_range(0, 1) == 1, a[1],
            $urandom_range(0, 1) == 1, a[2], $urandom_range(0, 19) == 0,
            $urandom_range(0, 2) != 0);
      n_vec++; if (occupancy_o !== 4'(exp_q.size())) begin n_err++; $display("FAIL rand_occ: got %0d expected %0d", occupancy_o, exp_q.size()); end
      n_vec++; if (drop_count_o !== 16'(exp_drops)) begin n_err++; $display("FAIL rand_drops: got %0d expected %0d", drop_count_o, exp_drops); end
    end
  endtask

  task automatic test_saturate();
    logic [AW-1:0] base;
    for (int i = 0; i < 8 && exp_q.size() < DEPTH; i++)
      cycle(1, 64'h3000_0000 + 64'(i) * 64'h100, 1, 64'h3000_0040 + 64'(i) * 64'h100,
            1, 64'h3000_0080 + 64'(i) * 64'h100, 0, 0);
    for (int i = 0; i < 25000 && exp_drops < 65535; i++) begin
      base = 64'h4000_0000 + 64'(i) * 64'h100;
      cycle(1, base, 1, base + 64'h40, 1, base + 64'h80, 0, 0);
    end
    n_vec++; if (drop_count_o !== 16'hFFFF) begin n_err++; $display("FAIL sat_reach: got %h expected ffff", drop_count_o); end
    cycle(1, 64'h5000_0000, 1, 64'h5000_0040, 1, 64'h5000_0080, 0, 0);
    n_vec++; if (drop_count_o !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %h expected ffff", drop_count_o); end
    n_vec++; if (occupancy_o !== 4'd8) begin n_err++; $display("FAIL sat_occ: got %0d expected 8", occupancy_o); end
  endtask

  task automatic test_async_reset();
    #3;
    rst = 1'b0;
    pref_valid1_i = 0; pref_valid2_i = 0; pref_valid3_i = 0;
    flush_i = 0; req_ready_i = 0;
    #1;
    n_vec++; if (req_valid_o !== 1'b0) begin n_err++; $display("FAIL areset_valid: got %b expected 0", req_valid_o); end
    n_vec++; if (occupancy_o !== 4'd0) begin n_err++; $display("FAIL areset_occ: got %0d expected 0", occupancy_o); end
    n_vec++; if (drop_count_o !== 16'd0) begin n_err++; $display("FAIL areset_drops: got %0d expected 0", drop_count_o); end
    exp_q.delete();
    exp_drops = 0;
    @(negedge clk); #2; rst = 1'b1;
    cycle(1, 64'h6040, 0, 64'h0, 0, 64'h0, 0, 1);
    n_vec++; if (req_valid_o !== 1'b1) begin n_err++; $display("FAIL post_reset_valid: got %b expected 1", req_valid_o); end
    n_vec++; if (req_addr_o !== 64'h6040) begin n_err++; $display("FAIL post_reset_addr: got %h expected 6040", req_addr_o); end
    idle(1);
    n_vec++; if (occupancy_o !== 4'd0) begin n_err++; $display("FAIL post_reset_drain: got %0d expected 0", occupancy_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dup();
    test_overflow();
    test_full_wrap();
    test_flush();
    test_random();
    test_saturate();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
